sync_fifo_flags: RTL and testbench

- Single-clock synchronous FIFO, 8-bit data, 16 entries, registered read data.
- Outputs four status flags: empty, partially empty, full and partially full.
- Used as the buffering element between a byte producer (an LFSR data generator in the bench) and a consumer.
- Gate-level and behavioural models must match cycle-for-cycle.

---
 rtl/sync_fifo_flags.sv | 94 +++++++++
 tb/tb_sync_fifo_flags.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_flags.sv
// Single-clock 16x8 FIFO with registered read data and empty/partial/full status flags.
// Define FIFO_ERR_FLAGS_EN to add sticky overflow (OVF) and underflow (UDF) outputs.
module sync_fifo_flags #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PE_LVL = 4,
    parameter int unsigned PF_LVL = 12
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             WE,
    input  logic             RE,
    output logic [WIDTH-1:0] DOUT,
    output logic             EF,
    output logic             PEF,
    output logic             FF,
    output logic             PFF
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic             OVF,
    output logic             UDF
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PeCnt   = (AW + 1)'(PE_LVL);
    localparam logic [AW:0] PfCnt   = (AW + 1)'(PF_LVL);

    logic [AW:0]      wadd_q, radd_q;
    logic [AW:0]      count;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] dout_q;
    logic             wr_en, rd_en;

    // Flags come only from registered pointers, so they never see WE/RE.
    always_comb begin
        count = wadd_q - radd_q;
        EF    = (count == '0);
        FF    = (count == FullCnt);
        PEF   = (count <= PeCnt);
        PFF   = (count >= PfCnt);
        wr_en = WE && !FF;
        rd_en = RE && !EF;
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            wadd_q <= '0;
            radd_q <= '0;
            dout_q <= '0;
        end else begin
            if (wr_en) begin
                wadd_q <= wadd_q + 1'b1;
            end
            if (rd_en) begin
                radd_q <= radd_q + 1'b1;
                dout_q <= mem[radd_q[AW-1:0]];
            end
        end
    end

    // Storage has no reset; reads only ever touch entries already written.
    always_ff @(posedge clk) begin
        if (wr_en && !RESET) begin
            mem[wadd_q[AW-1:0]] <= DATA_IN;
        end
    end

    assign DOUT = dout_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (WE && FF) begin
                ovf_q <= 1'b1;
            end
            if (RE && EF) begin
                udf_q <= 1'b1;
            end
        end
    end

    assign OVF = ovf_q;
    assign UDF = udf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: fill/drain vector table plus hand-written corner sequences
// checked against a queue reference model.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] DATA_IN;
    logic       WE, RE;
    logic [7:0] DOUT;
    logic       EF, PEF, FF, PFF;
`ifdef FIFO_ERR_FLAGS_EN
    logic       OVF, UDF;
`endif

    sync_fifo_flags dut (
        .clk    (clk),
        .RESET  (RESET),
        .DATA_IN(DATA_IN),
        .WE     (WE),
        .RE     (RE),
        .DOUT   (DOUT),
        .EF     (EF),
        .PEF    (PEF),
        .FF     (FF),
        .PFF    (PFF)
`ifdef FIFO_ERR_FLAGS_EN
        ,
        .OVF    (OVF),
        .UDF    (UDF)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic       re;
        logic [7:0] din;
        logic [7:0] dout;
        logic       ef;
        logic       pef;
        logic       ff;
        logic       pff;
    } vec_t;

    vec_t       vecs [34];
    int         total = 0;
    int         bad = 0;
    logic [7:0] mq [$];
    logic [7:0] m_dout;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, " dout"}, 32'(DOUT), 32'(m_dout));
        chk({tag, " ef"}, 32'(EF), 32'(sz == 0));
        chk({tag, " pef"}, 32'(PEF), 32'(sz <= 4));
        chk({tag, " ff"}, 32'(FF), 32'(sz == 16));
        chk({tag, " pff"}, 32'(PFF), 32'(sz >= 12));
    endtask

    // One clock edge with given inputs; model follows pre-edge occupancy.
    task automatic step(input logic we, input logic re, input logic [7:0] d);
        logic do_w, do_r;
        @(negedge clk);
        WE = we;
        RE = re;
        DATA_IN = d;
        do_w = we && (mq.size() < 16);
        do_r = re && (mq.size() > 0);
        @(posedge clk);
        if (do_r) m_dout = mq.pop_front();
        if (do_w) mq.push_back(d);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        WE = 1'b0;
        RE = 1'b0;
        RESET = 1'b1;
        #2;
        RESET = 1'b0;
        mq.delete();
        m_dout = 8'h00;
    endtask

    initial begin
        logic [7:0] lfsr;
        logic [7:0] held;

        // Fill 1..16, 17th write dropped; then drain with 17th read ignored.
        for (int k = 1; k <= 17; k++) begin
            vecs[k-1] = '{we: 1'b1, re: 1'b0, din: (k == 17) ? 8'd99 : 8'(k), dout: 8'h00,
                          ef: 1'b0, pef: (k <= 4), ff: (k >= 16), pff: (k >= 12)};
        end
        for (int j = 1; j <= 17; j++) begin
            int c;
            c = (j >= 16) ? 0 : 16 - j;
            vecs[16+j] = '{we: 1'b0, re: 1'b1, din: 8'h00, dout: (j == 17) ? 8'd16 : 8'(j),
                           ef: (c == 0), pef: (c <= 4), ff: 1'b0, pff: (c >= 12)};
        end

        // Reset held with WE=RE=1: nothing accepted, outputs stay at reset values.
        RESET = 1'b1;
        WE = 1'b1;
        RE = 1'b1;
        DATA_IN = 8'h55;
        mq.delete();
        m_dout = 8'h00;
        for (int t = 0; t < 10; t++) begin
            #10;
            chk("rst dout", 32'(DOUT), 32'h0);
            chk("rst ef", 32'(EF), 32'h1);
            chk("rst pef", 32'(PEF), 32'h1);
            chk("rst ff", 32'(FF), 32'h0);
            chk("rst pff", 32'(PFF), 32'h0);
        end
        RESET = 1'b0;
        WE = 1'b0;
        RE = 1'b0;
        step(1'b0, 1'b0, 8'h00);
        chk_model("post-rst idle");

        for (int i = 0; i < 34; i++) begin
            step(vecs[i].we, vecs[i].re, vecs[i].din);
            chk($sformatf("vec%0d dout", i), 32'(DOUT), 32'(vecs[i].dout));
            chk($sformatf("vec%0d ef", i), 32'(EF), 32'(vecs[i].ef));
            chk($sformatf("vec%0d pef", i), 32'(PEF), 32'(vecs[i].pef));
            chk($sformatf("vec%0d ff", i), 32'(FF), 32'(vecs[i].ff));
            chk($sformatf("vec%0d pff", i), 32'(PFF), 32'(vecs[i].pff));
`ifdef FIFO_ERR_FLAGS_EN
            chk($sformatf("vec%0d ovf", i), 32'(OVF), 32'(i >= 16));
            chk($sformatf("vec%0d udf", i), 32'(UDF), 32'(i == 33));
`endif
        end

        // Count 8, then 20 simultaneous edges: output lags input by 8.
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h10 + 8'(i));
        for (int k = 0; k < 20; k++) begin
            step(1'b1, 1'b1, 8'h20 + 8'(k));
            chk($sformatf("sim8 dout%0d", k), 32'(DOUT),
                (k < 8) ? 32'h10 + 32'(k) : 32'h20 + 32'(k - 8));
            chk_model($sformatf("sim8 edge%0d", k));
        end

        // Empty with WE=RE=1: only the write lands, DOUT holds.
        while (mq.size() > 0) step(1'b0, 1'b1, 8'h00);
        held = m_dout;
        step(1'b1, 1'b1, 8'h77);
        chk("empty-sim ef", 32'(EF), 32'h0);
        chk("empty-sim dout", 32'(DOUT), 32'(held));
        step(1'b0, 1'b1, 8'h00);
        chk("empty-sim readback", 32'(DOUT), 32'h77);

        // Full with WE=RE=1: only the read lands, count drops to 15.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
        chk("full ff", 32'(FF), 32'h1);
        step(1'b1, 1'b1, 8'h88);
        chk("full-sim ff", 32'(FF), 32'h0);
        chk("full-sim dout", 32'(DOUT), 32'h40);
        chk("full-sim count15", 32'(mq.size()), 32'd15);
        chk_model("full-sim");

        // Continuous streaming across several pointer wraps.
        pulse_reset();
        lfsr = 8'h01;
        for (int k = 0; k < 50; k++) begin
            step(1'b1, 1'b1, lfsr);
            chk_model($sformatf("lfsr%0d", k));
            lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end

        // Asynchronous reset between edges at count 10.
        pulse_reset();
        for (int i = 0; i < 11; i++) step(1'b1, 1'b0, 8'hC0 + 8'(i));
        step(1'b0, 1'b1, 8'h00);
        chk("pre-arst dout", 32'(DOUT), 32'hC0);
        chk("pre-arst pff", 32'(PFF), 32'h0);
        step(1'b1, 1'b0, 8'hCB);
        step(1'b1, 1'b0, 8'hCC);
        chk("pre-arst pff12", 32'(PFF), 32'h1);
        step(1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b1, 8'h00);
        chk("pre-arst count10", 32'(mq.size()), 32'd10);
        @(negedge clk);
        WE = 1'b0;
        RE = 1'b0;
        #2;
        RESET = 1'b1;
        #1;
        chk("arst ef", 32'(EF), 32'h1);
        chk("arst pef", 32'(PEF), 32'h1);
        chk("arst pff", 32'(PFF), 32'h0);
        chk("arst dout", 32'(DOUT), 32'h0);
        mq.delete();
        m_dout = 8'h00;
        @(negedge clk);
        RESET = 1'b0;
        step(1'b1, 1'b0, 8'hAA);
        step(1'b0, 1'b1, 8'h00);
        chk("arst readback", 32'(DOUT), 32'hAA);
        chk_model("arst final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
